// File: rtl/frame_loader.sv
// frame_loader: sync-framed byte stream -> 64 registered RGB pixel writes (1-cycle latency), then a send_frame swap request.
// rx_ready is low from the final write until the post-swap gap ends; FRAME_LOADER_TIMEOUT_EN adds an inter-byte timeout.
module frame_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned N_PIXELS  = 64
`ifdef FRAME_LOADER_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        frame_done,
  output logic        write_en,
  output logic [5:0]  pixel_addr,
  output logic [23:0] pixel_value,
  output logic        send_frame,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RECV, WAIT_DONE, SWAP_GAP} state_t;

  localparam logic [5:0] LAST_PIX = 6'(N_PIXELS - 1);

  state_t      state, state_nxt;
  logic [1:0]  byte_idx, byte_idx_nxt;
  logic [5:0]  pix_idx, pix_idx_nxt;
  logic [1:0]  gap_cnt, gap_cnt_nxt;
  logic [15:0] asm_reg;
  logic        pix_write;
  logic        swap_req;
  logic        timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_idx <= '0;
      pix_idx  <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
      pix_idx  <= pix_idx_nxt;
      gap_cnt  <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    pix_idx_nxt  = pix_idx;
    gap_cnt_nxt  = gap_cnt;
    pix_write    = 1'b0;
    swap_req     = 1'b0;
    rx_ready     = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_nxt    = RECV;
          byte_idx_nxt = '0;
          pix_idx_nxt  = '0;
        end
      end
      RECV: begin
        rx_ready = 1'b1;
        if (timeout) begin
          state_nxt    = IDLE;
          byte_idx_nxt = '0;
          pix_idx_nxt  = '0;
        end else if (rx_valid) begin
          if (byte_idx == 2'd2) begin
            pix_write    = 1'b1;
            byte_idx_nxt = '0;
            // pix_idx holds at the last address instead of wrapping to 0
            if (pix_idx == LAST_PIX) state_nxt = WAIT_DONE;
            else                     pix_idx_nxt = pix_idx + 6'd1;
          end else begin
            byte_idx_nxt = byte_idx + 2'd1;
          end
        end
      end
      WAIT_DONE: begin
        // a frame_done landing on the final write cycle is too early to swap on
        if (frame_done && !write_en) begin
          state_nxt   = SWAP_GAP;
          swap_req    = 1'b1;
          gap_cnt_nxt = '0;
        end
      end
      SWAP_GAP: begin
        if (gap_cnt == 2'd2) state_nxt = IDLE;
        else                 gap_cnt_nxt = gap_cnt + 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_reg     <= '0;
      write_en    <= 1'b0;
      pixel_addr  <= '0;
      pixel_value <= '0;
      send_frame  <= 1'b0;
    end else begin
      write_en   <= pix_write;
      send_frame <= swap_req;
      if (state == RECV && rx_valid) asm_reg <= {asm_reg[7:0], rx_data};
      if (pix_write) begin
        pixel_addr  <= pix_idx;
        pixel_value <= {asm_reg, rx_data};
      end
    end
  end

`ifdef FRAME_LOADER_TIMEOUT_EN
  logic [15:0] idle_cnt;

  assign timeout = (state == RECV) && (idle_cnt == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= timeout;
      if (state == RECV && !rx_valid && !timeout) idle_cnt <= idle_cnt + 16'd1;
      else                                         idle_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
